// File: rtl/tlul_steer_pkg.sv
// -----------------------------------------------------------------------------
// tlul_steer_pkg
// Shared definitions for the TL-UL 1:N steering controller.
//   steer_state_e : controller state (IDLE / ACTIVE / DRAIN)
//   DepthFieldW   : width of one per-device field in the packed depth vector
//   dev_depth()   : extracts device i's field from a packed depth vector
// -----------------------------------------------------------------------------
package tlul_steer_pkg;

    localparam int unsigned DepthFieldW  = 4;
    localparam int unsigned MaxDevs      = 15;
    localparam int unsigned DepthVecMaxW = DepthFieldW * (MaxDevs + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } steer_state_e;

    // Depth vector is zero-extended by the caller, so indices past the real
    // device count read back 0.
    function automatic logic [DepthFieldW-1:0] dev_depth(
        input logic [DepthVecMaxW-1:0] depth_vec,
        input int unsigned             idx
    );
        return depth_vec[DepthFieldW*idx +: DepthFieldW];
    endfunction

endpackage

// File: rtl/tlul_steer_ctrl_if.sv
// -----------------------------------------------------------------------------
// tlul_steer_ctrl_if
// Host/device handshake bundle for tlul_steer_ctrl.
//   host A : host_a_valid_i, dev_sel_i (in) / host_a_ready_o (out)
//   dev A  : dev_a_valid_o (out, N+1) / dev_a_ready_i (in, N+1)
//   dev D  : dev_d_valid_i (in, N+1) / dev_d_ready_o (out, N+1)
//   host D : host_d_valid_o (out) / host_d_ready_i (in), d_sel_o (out)
// Modports: master = environment side, slave = controller side.
// -----------------------------------------------------------------------------
interface tlul_steer_ctrl_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned SelW = $clog2(N + 1)
);
    logic            host_a_valid_i;
    logic            host_a_ready_o;
    logic [SelW-1:0] dev_sel_i;
    logic [N:0]      dev_a_valid_o;
    logic [N:0]      dev_a_ready_i;
    logic [N:0]      dev_d_valid_i;
    logic [N:0]      dev_d_ready_o;
    logic            host_d_valid_o;
    logic            host_d_ready_i;
    logic [SelW-1:0] d_sel_o;

    modport master (
        output host_a_valid_i, dev_sel_i, dev_a_ready_i, dev_d_valid_i, host_d_ready_i,
        input  host_a_ready_o, dev_a_valid_o, dev_d_ready_o, host_d_valid_o, d_sel_o
    );

    modport slave (
        input  host_a_valid_i, dev_sel_i, dev_a_ready_i, dev_d_valid_i, host_d_ready_i,
        output host_a_ready_o, dev_a_valid_o, dev_d_ready_o, host_d_valid_o, d_sel_o
    );
endinterface

// File: rtl/tlul_steer_cnt.sv
// -----------------------------------------------------------------------------
// tlul_steer_cnt
// Outstanding-request up/down counter.
//   clk_i, rst_ni : clock, async active-low reset
//   inc, dec      : increment / decrement requests (both = hold)
//   lim           : current limit for the at_lim compare
//   cnt, cnt_nxt  : registered count and its next value
//   at_lim        : cnt >= lim
// -----------------------------------------------------------------------------
module tlul_steer_cnt #(
    parameter int unsigned CntW = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc,
    input  logic            dec,
    input  logic [CntW-1:0] lim,
    output logic [CntW-1:0] cnt,
    output logic [CntW-1:0] cnt_nxt,
    output logic            at_lim
);
    always_comb begin
        cnt_nxt = cnt;
        if (inc && !dec) begin
            cnt_nxt = cnt + CntW'(1);
        end else if (dec && !inc) begin
            cnt_nxt = cnt - CntW'(1);
        end
    end

    assign at_lim = (cnt >= lim);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/tlul_steer_ctrl.sv
// -----------------------------------------------------------------------------
// tlul_steer_ctrl
// Steering controller for a 1:N TL-UL socket. Routes host A requests to one of
// N devices or the error responder (index N), keeps responses in issue order
// by only switching target once all outstanding responses have returned.
//   clk_i, rst_ni  : clock, async active-low reset
//   bus            : tlul_steer_ctrl_if.slave handshake bundle
//   block_i        : stop accepting requests and drain
//   outstanding_o  : outstanding request count
//   idle_o         : count is 0 and state is IDLE
//   stall_cnt_o    : (TLUL_STEER_STATS_EN only) saturating count of cycles
//                    stalled solely by a target switch
// Optional feature macro: TLUL_STEER_STATS_EN
// -----------------------------------------------------------------------------
module tlul_steer_ctrl
    import tlul_steer_pkg::*;
#(
    parameter int unsigned     N              = 4,
    parameter int unsigned     MaxOutstanding = 8,
    parameter bit [4*N-1:0]    DevDepth       = 16'h2222,
    parameter int unsigned     CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    tlul_steer_ctrl_if.slave   bus,
    input  logic               block_i,
    output logic [CntW-1:0]    outstanding_o,
`ifdef TLUL_STEER_STATS_EN
    output logic [15:0]        stall_cnt_o,
`endif
    output logic               idle_o
);
    localparam int unsigned SelW = $clog2(N + 1);
    localparam logic [DepthVecMaxW-1:0] DepthVec = DepthVecMaxW'(DevDepth);

    steer_state_e    state;
    logic [SelW-1:0] tgt;
    logic [SelW-1:0] steer_q;
    logic [CntW-1:0] lim;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_nxt;
    logic            at_lim;
    logic            cnt_nz;
    logic            same_tgt;
    logic            go;
    logic            a_hs;
    logic            d_hs;
    logic [N:0]      a_valid;
    logic [N:0]      d_ready;

    // Out-of-range selects and disabled devices go to the error responder.
    always_comb begin
        tgt = SelW'(N);
        if (bus.dev_sel_i < SelW'(N) &&
            dev_depth(DepthVec, int'(bus.dev_sel_i)) != '0) begin
            tgt = bus.dev_sel_i;
        end
    end

    always_comb begin
        lim = CntW'(MaxOutstanding);
        if (tgt != SelW'(N) &&
            int'(dev_depth(DepthVec, int'(tgt))) < int'(MaxOutstanding)) begin
            lim = CntW'(dev_depth(DepthVec, int'(tgt)));
        end
    end

    assign cnt_nz   = (cnt != '0);
    assign same_tgt = !cnt_nz || (tgt == steer_q);
    assign go       = bus.host_a_valid_i && !block_i && !at_lim && same_tgt;
    assign a_hs     = go && bus.dev_a_ready_i[tgt];
    assign d_hs     = cnt_nz && bus.host_d_ready_i && bus.dev_d_valid_i[steer_q];

    always_comb begin
        a_valid          = '0;
        d_ready          = '0;
        a_valid[tgt]     = bus.host_a_valid_i && go;
        d_ready[steer_q] = cnt_nz && bus.host_d_ready_i;
    end

    assign bus.dev_a_valid_o  = a_valid;
    assign bus.dev_d_ready_o  = d_ready;
    assign bus.host_a_ready_o = a_hs;
    assign bus.host_d_valid_o = cnt_nz && bus.dev_d_valid_i[steer_q];
    assign bus.d_sel_o        = steer_q;
    assign outstanding_o      = cnt;
    assign idle_o             = !cnt_nz && (state == IDLE);

    tlul_steer_cnt #(
        .CntW (CntW)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc     (a_hs),
        .dec     (d_hs),
        .lim     (lim),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .at_lim  (at_lim)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            steer_q <= '0;
        end else begin
            if (a_hs) begin
                steer_q <= tgt;
            end
            unique case (state)
                IDLE: begin
                    if (a_hs) state <= ACTIVE;
                end
                ACTIVE: begin
                    // Reaching zero wins over block: nothing left to drain.
                    if (cnt_nxt == '0)  state <= IDLE;
                    else if (block_i)   state <= DRAIN;
                end
                DRAIN: begin
                    if (cnt_nxt == '0)  state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TLUL_STEER_STATS_EN
    logic switch_stall;

    assign switch_stall = bus.host_a_valid_i && !block_i && !at_lim &&
                          cnt_nz && (tgt != steer_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (switch_stall && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tlul_steer_ctrl.sv
module tb_tlul_steer_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned MaxO  = 8;
    localparam logic [15:0] DEPTH = 16'h2222;

    logic       clk;
    logic       rst_ni;
    logic       block;
    logic [3:0] outstanding;
    logic       idle;
    logic       block2;
    logic [3:0] outstanding2;
    logic       idle2;
`ifdef TLUL_STEER_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt2;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    tlul_steer_ctrl_if #(.N(N)) bus  ();
    tlul_steer_ctrl_if #(.N(N)) bus2 ();

    tlul_steer_ctrl #(
        .N              (N),
        .MaxOutstanding (MaxO),
        .DevDepth       (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .bus           (bus),
        .block_i       (block),
        .outstanding_o (outstanding),
`ifdef TLUL_STEER_STATS_EN
        .stall_cnt_o   (stall_cnt),
`endif
        .idle_o        (idle)
    );

    // Second instance with device 3 disabled.
    tlul_steer_ctrl #(
        .N              (N),
        .MaxOutstanding (MaxO),
        .DevDepth       (16'h0222)
    ) dut2 (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .bus           (bus2),
        .block_i       (block2),
        .outstanding_o (outstanding2),
`ifdef TLUL_STEER_STATS_EN
        .stall_cnt_o   (stall_cnt2),
`endif
        .idle_o        (idle2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] sel;
        logic       blk;
        logic [4:0] ardy;
        logic [4:0] dval;
        logic       hdr;
        logic       e_ardy;
        logic [4:0] e_aval;
        logic       e_dval;
        logic [4:0] e_drdy;
        logic [2:0] e_dsel;
        logic [3:0] e_out;
        logic       e_idle;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic v, input logic [2:0] sel, input logic blk, input logic [4:0] ardy,
        input logic [4:0] dval, input logic hdr, input logic e_ardy, input logic [4:0] e_aval,
        input logic e_dval, input logic [4:0] e_drdy, input logic [2:0] e_dsel,
        input logic [3:0] e_out, input logic e_idle);
        vec_t r;
        r.v = v; r.sel = sel; r.blk = blk; r.ardy = ardy; r.dval = dval; r.hdr = hdr;
        r.e_ardy = e_ardy; r.e_aval = e_aval; r.e_dval = e_dval; r.e_drdy = e_drdy;
        r.e_dsel = e_dsel; r.e_out = e_out; r.e_idle = e_idle;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic blk,
                         input logic [4:0] ardy, input logic [4:0] dval, input logic hdr);
        bus.host_a_valid_i = v;
        bus.dev_sel_i      = sel;
        block              = blk;
        bus.dev_a_ready_i  = ardy;
        bus.dev_d_valid_i  = dval;
        bus.host_d_ready_i = hdr;
    endtask

    task automatic check_outs(input string tag, input logic e_ardy, input logic [4:0] e_aval,
                              input logic e_dval, input logic [4:0] e_drdy, input logic [2:0] e_dsel,
                              input logic [3:0] e_out, input logic e_idle);
        chk({tag, ".host_a_ready"}, 32'(bus.host_a_ready_o), 32'(e_ardy));
        chk({tag, ".dev_a_valid"},  32'(bus.dev_a_valid_o),  32'(e_aval));
        chk({tag, ".host_d_valid"}, 32'(bus.host_d_valid_o), 32'(e_dval));
        chk({tag, ".dev_d_ready"},  32'(bus.dev_d_ready_o),  32'(e_drdy));
        chk({tag, ".d_sel"},        32'(bus.d_sel_o),        32'(e_dsel));
        chk({tag, ".outstanding"},  32'(outstanding),        32'(e_out));
        chk({tag, ".idle"},         32'(idle),               32'(e_idle));
    endtask

    // Reference model: depth field of a device from the packed parameter.
    function automatic int field_of(input int i);
        logic [15:0] d;
        d = DEPTH;
        return (i < int'(N)) ? int'((d >> (4 * i)) & 16'hF) : 0;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   q[$];
        int   steer_m;

        rst_ni = 1'b0;
        block2 = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 5'h1F, 5'h00, 1'b0);
        bus2.host_a_valid_i = 1'b0;
        bus2.dev_sel_i      = '0;
        bus2.dev_a_ready_i  = '0;
        bus2.dev_d_valid_i  = '0;
        bus2.host_d_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Disabled device / out-of-range select routing on dut2 (no ready, no accept).
        @(negedge clk);
        bus2.host_a_valid_i = 1'b1;
        bus2.dev_sel_i = 3'd3; #2;
        chk("dis3.dev_a_valid", 32'(bus2.dev_a_valid_o), 32'h10);
        chk("dis3.host_a_ready", 32'(bus2.host_a_ready_o), 32'h0);
        bus2.dev_sel_i = 3'd2; #1;
        chk("dev2.dev_a_valid", 32'(bus2.dev_a_valid_o), 32'h04);
        bus2.dev_sel_i = 3'd5; #1;
        chk("sel5.dev_a_valid", 32'(bus2.dev_a_valid_o), 32'h10);
        bus2.host_a_valid_i = 1'b0; #1;
        chk("dut2.idle", 32'(idle2), 32'h1);

        // Directed table: each row is one cycle, checked before the next rising edge.
        //                v  sel  blk ardy   dval   hdr | ardy aval  dval drdy  dsel out idle
        tbl.push_back(mk(0, 3'd0, 0, 5'h1F, 5'h00, 0,   0, 5'h00, 0, 5'h00, 3'd0, 4'd0, 1)); // reset state
        tbl.push_back(mk(1, 3'd1, 0, 5'h1D, 5'h00, 0,   0, 5'h02, 0, 5'h00, 3'd0, 4'd0, 1)); // dev not ready
        tbl.push_back(mk(1, 3'd1, 0, 5'h1F, 5'h00, 0,   1, 5'h02, 0, 5'h00, 3'd0, 4'd0, 1));
        tbl.push_back(mk(1, 3'd1, 0, 5'h1F, 5'h00, 0,   1, 5'h02, 0, 5'h00, 3'd1, 4'd1, 0));
        tbl.push_back(mk(1, 3'd1, 0, 5'h1F, 5'h00, 0,   0, 5'h00, 0, 5'h00, 3'd1, 4'd2, 0)); // at limit
        tbl.push_back(mk(0, 3'd0, 0, 5'h1F, 5'h02, 1,   0, 5'h00, 1, 5'h02, 3'd1, 4'd2, 0));
        tbl.push_back(mk(0, 3'd0, 0, 5'h1F, 5'h02, 1,   0, 5'h00, 1, 5'h02, 3'd1, 4'd1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 5'h1F, 5'h00, 0,   0, 5'h00, 0, 5'h00, 3'd1, 4'd0, 1));
        tbl.push_back(mk(1, 3'd0, 0, 5'h1F, 5'h00, 0,   1, 5'h01, 0, 5'h00, 3'd1, 4'd0, 1));
        tbl.push_back(mk(1, 3'd2, 0, 5'h1F, 5'h00, 0,   0, 5'h00, 0, 5'h00, 3'd0, 4'd1, 0)); // switch stall
        tbl.push_back(mk(1, 3'd2, 0, 5'h1F, 5'h01, 1,   0, 5'h00, 1, 5'h01, 3'd0, 4'd1, 0));
        tbl.push_back(mk(1, 3'd2, 0, 5'h1F, 5'h00, 0,   1, 5'h04, 0, 5'h00, 3'd0, 4'd0, 1));
        tbl.push_back(mk(1, 3'd2, 0, 5'h1F, 5'h04, 1,   1, 5'h04, 1, 5'h04, 3'd2, 4'd1, 0)); // A+D same cycle
        tbl.push_back(mk(0, 3'd0, 0, 5'h1F, 5'h04, 1,   0, 5'h00, 1, 5'h04, 3'd2, 4'd1, 0));
        tbl.push_back(mk(1, 3'd5, 0, 5'h1F, 5'h00, 0,   1, 5'h10, 0, 5'h00, 3'd2, 4'd0, 1)); // sel 5 -> err
        tbl.push_back(mk(1, 3'd6, 0, 5'h1F, 5'h00, 0,   1, 5'h10, 0, 5'h00, 3'd4, 4'd1, 0));
        tbl.push_back(mk(1, 3'd6, 1, 5'h1F, 5'h0F, 1,   0, 5'h00, 0, 5'h10, 3'd4, 4'd2, 0)); // block, stray D
        tbl.push_back(mk(1, 3'd6, 1, 5'h1F, 5'h10, 1,   0, 5'h00, 1, 5'h10, 3'd4, 4'd2, 0));
        tbl.push_back(mk(0, 3'd0, 1, 5'h1F, 5'h10, 1,   0, 5'h00, 1, 5'h10, 3'd4, 4'd1, 0));
        tbl.push_back(mk(1, 3'd4, 1, 5'h1F, 5'h00, 0,   0, 5'h00, 0, 5'h00, 3'd4, 4'd0, 1)); // idle + block
        tbl.push_back(mk(0, 3'd0, 0, 5'h1F, 5'h00, 0,   0, 5'h00, 0, 5'h00, 3'd4, 4'd0, 1));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].sel, tbl[i].blk, tbl[i].ardy, tbl[i].dval, tbl[i].hdr);
            #2;
            check_outs($sformatf("row%0d", i), tbl[i].e_ardy, tbl[i].e_aval, tbl[i].e_dval,
                       tbl[i].e_drdy, tbl[i].e_dsel, tbl[i].e_out, tbl[i].e_idle);
        end

        // Reset in the middle of a transaction with 3 outstanding.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 3'd7, 1'b0, 5'h1F, 5'h00, 1'b0);
            #2;
            check_outs($sformatf("fill%0d", k), 1'b1, 5'h10, 1'b0, 5'h00, 3'd4, 4'(k), (k == 0));
        end
        @(negedge clk);
        drive(1'b0, 3'd0, 1'b0, 5'h1F, 5'h10, 1'b1);
        #2;
        check_outs("pre_rst", 1'b0, 5'h00, 1'b1, 5'h10, 3'd4, 4'd3, 1'b0);
        rst_ni = 1'b0;
        #1;
        check_outs("in_rst", 1'b0, 5'h00, 1'b0, 5'h00, 3'd0, 4'd0, 1'b1);
        @(negedge clk);
        rst_ni = 1'b1;
        #2;
        check_outs("post_rst", 1'b0, 5'h00, 1'b0, 5'h00, 3'd0, 4'd0, 1'b1);
        @(negedge clk);
        #2;
        check_outs("post_rst2", 1'b0, 5'h00, 1'b0, 5'h00, 3'd0, 4'd0, 1'b1);

        // Randomized phase against a queue-based model of outstanding requests.
        q.delete();
        steer_m = 0;
        for (int c = 0; c < 3000; c++) begin
            logic       v, blk, hdr;
            logic [2:0] sel;
            logic [4:0] ardy, dval;
            int         n, tg, lim, fld;
            logic       go, a_hs, d_hs;
            logic [4:0] e_aval, e_drdy;

            v    = ($urandom % 10) < 7;
            sel  = 3'($urandom_range(0, 7));
            blk  = ($urandom % 10) == 0;
            ardy = 5'($urandom);
            dval = 5'($urandom);
            hdr  = ($urandom % 4) != 0;
            @(negedge clk);
            drive(v, sel, blk, ardy, dval, hdr);
            #2;

            n   = q.size();
            fld = field_of(int'(sel));
            tg  = (int'(sel) >= int'(N) || fld == 0) ? int'(N) : int'(sel);
            lim = (tg == int'(N)) ? int'(MaxO) : ((fld < int'(MaxO)) ? fld : int'(MaxO));
            go  = v && !blk && (n < lim) && (n == 0 || tg == steer_m);
            a_hs = go && ardy[tg];
            d_hs = (n != 0) && hdr && dval[steer_m];
            e_aval = go ? 5'(1 << tg) : 5'h00;
            e_drdy = ((n != 0) && hdr) ? 5'(1 << steer_m) : 5'h00;

            check_outs("rnd", a_hs, e_aval, (n != 0) && dval[steer_m], e_drdy,
                       3'(steer_m), 4'(n), (n == 0));

            if (d_hs) void'(q.pop_front());
            if (a_hs) begin
                q.push_back(tg);
                steer_m = tg;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/tlul_steer_ctrl.md
# tlul_steer_ctrl

Steering controller for the 1:N TL-UL socket. Routes each host A-channel request to one of N devices (or the error responder), tracks outstanding requests, and returns D-channel responses in issue order. A new request to a different device is accepted only after all previous responses have returned. Per-device outstanding limits are taken from the same packed 4-bit-per-device depth parameter the socket uses for its FIFO depths.

## Interface
- `N`, 4 — number of devices; vector index `N` is the error responder.
- `MaxOutstanding`, 8 — global cap on outstanding requests (1..15).
- `DevDepth`, `bit [4*N-1:0]`, `16'h2222` — device `i` limit is `DevDepth[4*i+:4]`; field value 0 marks the device disabled.
- Derived: `SelW = $clog2(N+1)`, `CntW = $clog2(MaxOutstanding+1)`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `host_a_valid_i` / `host_a_ready_o`  in/out  1  host request handshake.
- `dev_sel_i`  in  SelW  target device, valid with `host_a_valid_i`.
- `dev_a_valid_o` / `dev_a_ready_i`  out/in  N+1  per-target request handshake.
- `dev_d_valid_i` / `dev_d_ready_o`  in/out  N+1  per-target response handshake.
- `host_d_valid_o` / `host_d_ready_i`  out/in  1  host response handshake.
- `d_sel_o`  out  SelW  source index for the response data mux (`steer_q`).
- `block_i`  in  1  stop accepting requests and drain.
- `outstanding_o`  out  CntW  current outstanding count.
- `idle_o`  out  1  count is 0 and state is IDLE.

## Operation
- Effective target `tgt`: if `dev_sel_i >= N` or `DevDepth` field is 0, use `N`; otherwise use `dev_sel_i`.
- Limit `lim(tgt)`:
  - `min(MaxOutstanding, field)` for a device.
  - `MaxOutstanding` for the error responder.
- Request accept condition `go`, all of:
  - `host_a_valid_i`
  - `!block_i`
  - `cnt < lim(tgt)`
  - `cnt == 0 || tgt == steer_q`
- A-channel routing:
  - `dev_a_valid_o[tgt] = host_a_valid_i & go`; all other bits are 0.
  - `host_a_ready_o = go & dev_a_ready_i[tgt]`.
- On an A handshake, `steer_q <= tgt`.
- D-channel:
  - `host_d_valid_o = (cnt != 0) & dev_d_valid_i[steer_q]`.
  - `dev_d_ready_o[steer_q] = (cnt != 0) & host_d_ready_i`; all other bits are 0.
  - A `dev_d_valid_i` at a non-steered index is ignored.
- Counter update:
  - +1 on A handshake only; −1 on D handshake only.
  - Both in the same cycle: hold.
  - Never wraps. Increment at limit is impossible by construction; a decrement at 0 is impossible because `dev_d_ready_o` is gated by `cnt != 0`.
- State machine:
  - IDLE → ACTIVE on an A handshake.
  - ACTIVE → IDLE when count reaches 0.
  - ACTIVE → DRAIN when `block_i` rises.
  - DRAIN → IDLE at count 0.
  - IDLE with `block_i` high stays IDLE, no accepts.
- `steer_q` changes only on an A handshake, so responses already in flight always return from the original device.

## Timing
- A and D paths are combinational pass-through (zero latency).
- `cnt`, `steer_q` and `state` are registered.
- Reset values:
  - `cnt = 0`, `steer_q = 0`, `state = IDLE`.
  - `host_a_ready_o = 0` (until `host_a_valid_i` is seen), `dev_a_valid_o = 0`, `dev_d_ready_o = 0`, `host_d_valid_o = 0`.
  - `d_sel_o = 0`, `outstanding_o = 0`, `idle_o = 1`.
- Reset asserted mid-transaction clears all state immediately. Responses arriving after reset are dropped (`cnt == 0`).
- `block_i` takes effect in the same cycle: `go` drops combinationally.

## Configuration
- `TLUL_STEER_STATS_EN` defined:
  - Adds output `stall_cnt_o` [15:0], a saturating count of cycles where `host_a_valid_i` is high and `go` is low only because `tgt != steer_q`.
  - Saturates at `16'hFFFF`; resets to 0.
- Undefined: port absent and no counter logic.

## Structure
- Shared package `tlul_steer_pkg` holds:
  - the `steer_state_e` enum {IDLE, ACTIVE, DRAIN};
  - the function `dev_depth(DevDepth, i)` that extracts a 4-bit field;
  - the `DepthFieldW = 4` constant.
- One sub-module, `tlul_steer_cnt`: CntW up/down counter with hold-on-both and an `at_lim` compare.

## Test plan
- N=4, default depths: send 2 requests to dev 1 without responses.
  - Third request to dev 1 stalls: `host_a_ready_o = 0`, `outstanding_o = 2`.
- 1 outstanding on dev 0, then request dev 2.
  - Stalls until the dev 0 D handshake, then is accepted; `d_sel_o` becomes 2.
- `dev_sel_i = 5`, or dev 3 with `DevDepth[15:12] = 0`.
  - Routed to index 4: `dev_a_valid_o = 5'b10000`.
- A and D handshakes in the same cycle at `cnt = 1`.
  - `cnt` stays 1; state stays ACTIVE.
- Assert `block_i` with `cnt = 2`.
  - No further accepts; state goes DRAIN → IDLE after 2 responses; `idle_o = 1`.
- Pull `rst_ni` low with `cnt = 3` in ACTIVE.
  - All outputs at reset values next sample; `dev_d_valid_i[steer]` is ignored.
